mux_rr_feeder: RTL

- Upstream stage of the 4:1 nibble mux.
- Accepts up to four independent request channels, each with a 4-bit payload and a valid/ready handshake.
- Holds each payload in a one-entry slot and schedules the slots round-robin.
- Drives the mux data inputs a..d and select sel as registered outputs, plus a valid/ready handshake toward the consumer of mux output y.

---
 rtl/mux_rr_feeder_pkg.sv | 19 +
 rtl/mux_rr_feeder_pick.sv | 27 ++
 rtl/mux_rr_feeder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mux_rr_feeder_pkg.sv
// Shared types and helpers for the round-robin feeder of the 4:1 nibble mux.
package mux_rr_pkg;

    localparam int DW  = 4;
    localparam int NCH = 4;

    typedef logic [1:0]    chan_t;
    typedef logic [DW-1:0] nib_t;

    typedef enum logic {
        IDLE,
        GRANT
    } fsm_t;

    function automatic chan_t next_rr(input chan_t c);
        return c + chan_t'(1);
    endfunction

endpackage

// File: rtl/mux_rr_feeder_pick.sv
// Combinational round-robin pick: first full slot at or after ptr, wrapping 3->0.
module mux_rr_pick
    import mux_rr_pkg::*;
(
    input  logic [NCH-1:0] full,
    input  chan_t          ptr,
    output logic           hit,
    output chan_t          idx
);

    chan_t cand;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit  = 1'b0;
        idx  = ptr;
        cand = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = ptr + chan_t'(i);
            if (!hit && full[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_feeder.sv
// Four one-entry request slots scheduled round-robin onto the nibble mux inputs.
// Optional MUX_RR_FEEDER_STATS_EN adds per-channel grant counters and a starve pulse.
module mux_rr_feeder
    import mux_rr_pkg::*;
#(
    parameter int unsigned DWELL = 1    // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output nib_t              a,
    output nib_t              b,
    output nib_t              c,
    output nib_t              d,
    output chan_t             sel,
    output logic              out_valid,
`ifdef MUX_RR_FEEDER_STATS_EN
    output logic [NCH*8-1:0]  grant_cnt,
    output logic              starve,
`endif
    input  logic              out_ready
);

    typedef logic [3:0] dwell_t;
    localparam dwell_t DWELL_INIT = dwell_t'(DWELL - 1);

    fsm_t           state_q, state_d;
    logic [NCH-1:0] full_q, full_d;
    logic [NCH-1:0] in_ready_q, in_ready_d;
    nib_t           slot_q [NCH];
    nib_t           slot_d [NCH];
    chan_t          ptr_q, ptr_d;
    chan_t          sel_q, sel_d;
    logic           out_valid_q, out_valid_d;
    dwell_t         dwell_q, dwell_d;
    logic           xfer;
    logic           pick_hit;
    chan_t          pick_idx;

    mux_rr_pick u_pick (
        .full (full_q),
        .ptr  (ptr_q),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        slot_d      = slot_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        dwell_d     = dwell_q;
        xfer        = 1'b0;

        for (int k = 0; k < NCH; k++) begin
            if (in_valid[k] && in_ready_q[k]) begin
                full_d[k] = 1'b1;
                slot_d[k] = in_data[k*DW +: DW];
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    sel_d       = pick_idx;
                    out_valid_d = 1'b1;
                    dwell_d     = DWELL_INIT;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // sel and the granted slot stay frozen until the transfer edge.
                xfer = (dwell_q == '0) && out_valid_q && out_ready;
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - dwell_t'(1);
                end
                if (xfer) begin
                    full_d[sel_q] = 1'b0;
                    ptr_d         = next_rr(sel_q);
                    out_valid_d   = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = ~full_d;
    end

    // NOTE: slot registers drive the mux pins directly, so they are reset like any control flop.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            full_q      <= '0;
            in_ready_q  <= '1;
            ptr_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            dwell_q     <= '0;
            for (int k = 0; k < NCH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            in_ready_q  <= in_ready_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            dwell_q     <= dwell_d;
            for (int k = 0; k < NCH; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign a         = slot_q[0];
    assign b         = slot_q[1];
    assign c         = slot_q[2];
    assign d         = slot_q[3];
    assign sel       = sel_q;
    assign out_valid = out_valid_q;

`ifdef MUX_RR_FEEDER_STATS_EN
    logic [NCH*8-1:0] grant_cnt_q, grant_cnt_d;
    logic [3:0]       wait_q [NCH];
    logic [3:0]       wait_d [NCH];
    logic             starve_q, starve_d;

    // A slot's wait count saturates at 9; the starve pulse fires on the 8->9 step.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        starve_d    = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            wait_d[k] = wait_q[k];
            if (xfer && sel_q == chan_t'(k)) begin
                grant_cnt_d[k*8 +: 8] = grant_cnt_q[k*8 +: 8] + 8'd1;
            end
            if (!full_q[k] || (out_valid_q && sel_q == chan_t'(k))) begin
                wait_d[k] = '0;
            end else if (wait_q[k] != 4'd9) begin
                wait_d[k] = wait_q[k] + 4'd1;
                if (wait_q[k] == 4'd8) begin
                    starve_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            starve_q    <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                wait_q[k] <= '0;
            end
        end else begin
            grant_cnt_q <= grant_cnt_d;
            starve_q    <= starve_d;
            for (int k = 0; k < NCH; k++) begin
                wait_q[k] <= wait_d[k];
            end
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign starve    = starve_q;
`endif

endmodule
